seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 18 +
 rtl/seq_alu_core.sv | 55 +++++
 rtl/seq_alu.sv | 138 +++++++++++++
 tb/tb_seq_alu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Opcodes and FSM state encoding shared by the sequential ALU.
package seq_alu_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_ASHL  = 3'b001;
   localparam logic [2:0] OP_XNOR  = 3'b010;
   localparam logic [2:0] OP_ASHR  = 3'b011;
   localparam logic [2:0] OP_PASSB = 3'b100;
   localparam logic [2:0] OP_PASSA = 3'b101;
   localparam logic [2:0] OP_NEG   = 3'b110;
   localparam logic [2:0] OP_ADC   = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/seq_alu_core.sv
// Single-cycle combinational datapath of the sequential ALU.
module seq_alu_core #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] res,
   output logic             co
);
   import seq_alu_pkg::*;

   logic [SHW-1:0]    amt;
   logic              cuse;
   logic [WIDTH:0]    sum;
   logic [WIDTH:0]    shl;
   logic signed [WIDTH:0] shr;

   assign amt  = b[SHW-1:0];
   assign cuse = cin & (sel == OP_ADC);
   assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cuse};
   assign shl  = {1'b0, a} << amt;
   // extra guard bit below the LSB catches the last bit shifted out
   assign shr  = $signed({a, 1'b0}) >>> amt;

   always_comb begin
      res = '0;
      co  = 1'b0;
      unique case (sel)
         OP_ADD, OP_ADC: begin
            res = sum[WIDTH-1:0];
            co  = sum[WIDTH];
         end
         OP_ASHL: begin
            res = shl[WIDTH-1:0];
            co  = shl[WIDTH];
         end
         OP_ASHR: begin
            res = shr[WIDTH:1];
            co  = shr[0];
         end
         OP_XNOR:  res = ~(a ^ b);
         OP_PASSB: res = b;
         OP_PASSA: res = a;
         OP_NEG:   res = (~a) + {{(WIDTH-1){1'b0}}, 1'b1};
         default: begin
            res = '0;
            co  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, optional bit-serial shifter,
// registered result and flags.
module seq_alu #(
   parameter int WIDTH      = 8,
   parameter int ITER_SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             zf,
   output logic             nf
);
   import seq_alu_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   logic [SHW-1:0]   count;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] snext;
   logic             sco;
   logic             snco;
   logic             sdir;
   logic             cflag;

   logic             accept;
   logic             iter;
   logic             can_wr;
   logic [WIDTH-1:0] core_res;
   logic             core_co;
   logic             wr_en;
   logic [WIDTH-1:0] wr_val;
   logic             wr_co;

   assign amt      = op2[SHW-1:0];
   assign can_wr   = !out_valid || out_ready;
   assign in_ready = !rst && (state == IDLE) && can_wr;
   assign accept   = in_valid && in_ready;
   assign iter     = (ITER_SHIFT != 0) && (amt != '0) &&
                     ((sel == OP_ASHL) || (sel == OP_ASHR));

   seq_alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .sel (sel),
      .a   (op1),
      .b   (op2),
      .cin (cflag),
      .res (core_res),
      .co  (core_co)
   );

   always_comb begin
      if (sdir) begin
         snext = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
         snco  = sreg[0];
      end else begin
         snext = {sreg[WIDTH-2:0], 1'b0};
         snco  = sreg[WIDTH-1];
      end
   end

   // last shift step writes straight through so latency is amt+1
   always_comb begin
      wr_en  = 1'b0;
      wr_val = core_res;
      wr_co  = core_co;
      if (state == IDLE) begin
         wr_en = accept && !iter;
      end else if (count == '0) begin
         wr_en  = can_wr;
         wr_val = sreg;
         wr_co  = sco;
      end else if (count == SHW'(1)) begin
         wr_en  = can_wr;
         wr_val = snext;
         wr_co  = snco;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out       <= '0;
         co        <= 1'b0;
         zf        <= 1'b0;
         nf        <= 1'b0;
         cflag     <= 1'b0;
         out_valid <= 1'b0;
         count     <= '0;
         sreg      <= '0;
         sco       <= 1'b0;
         sdir      <= 1'b0;
      end else begin
         if (wr_en) begin
            out       <= wr_val;
            co        <= wr_co;
            zf        <= (wr_val == '0);
            nf        <= wr_val[WIDTH-1];
            cflag     <= wr_co;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (accept && iter) begin
                  state <= SHIFT;
                  sreg  <= op1;
                  sco   <= 1'b0;
                  sdir  <= (sel == OP_ASHR);
                  count <= amt;
               end
            end
            SHIFT: begin
               if (count != '0) begin
                  sreg  <= snext;
                  sco   <= snco;
                  count <= count - SHW'(1);
               end
               if (wr_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH = 8),
// iterative and single-cycle shifter variants side by side.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] sel = 3'b000;
   logic [7:0] op1 = 8'h00;
   logic [7:0] op2 = 8'h00;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, co, zf, nf;
   logic [7:0] out;
   logic       in_ready1, out_valid1, co1, zf1, nf1;
   logic [7:0] out1;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8), .ITER_SHIFT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .op1(op1), .op2(op2), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .co(co), .zf(zf), .nf(nf)
   );

   seq_alu #(.WIDTH(8), .ITER_SHIFT(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .sel(sel), .op1(op1), .op2(op2), .out_valid(out_valid1),
      .out_ready(out_ready), .out(out1), .co(co1), .zf(zf1), .nf(nf1)
   );

   // one-cycle request; rdy reports in_ready just before the edge
   task automatic issue(input logic [2:0] s, input logic [7:0] a,
                        input logic [7:0] b, output logic rdy);
      @(negedge clk);
      sel = s; op1 = a; op2 = b; in_valid = 1'b1;
      #1 rdy = in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({in_ready, out_valid, out, co, zf, nf} !== 13'd0) begin
         failed++;
         $display("FAIL reset_state got rdy=%b v=%b out=%h co=%b zf=%b nf=%b",
                  in_ready, out_valid, out, co, zf, nf);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_add;
      logic r;
      int lat;
      issue(3'b000, 8'hF0, 8'h20, r);
      wait_valid(lat);
      tests++;
      if ({r, lat[3:0], out, co, zf, nf} !== {1'b1, 4'd1, 8'h10, 3'b100}) begin
         failed++;
         $display("FAIL add got rdy=%b lat=%0d out=%h co=%b zf=%b nf=%b want lat=1 out=10 co=1",
                  r, lat, out, co, zf, nf);
      end
      issue(3'b111, 8'h01, 8'h01, r);
      wait_valid(lat);
      tests++;
      if ({lat[3:0], out, co, zf, nf} !== {4'd1, 8'h03, 3'b000}) begin
         failed++;
         $display("FAIL adc got lat=%0d out=%h co=%b want out=03 co=0",
                  lat, out, co);
      end
   endtask

   task automatic test_ashl;
      logic r;
      int lat;
      lat = 0;
      issue(3'b001, 8'h61, 8'h02, r);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i <= 2) begin
            tests++;
            if (in_ready !== 1'b0) begin
               failed++;
               $display("FAIL ashl_busy cycle %0d in_ready=%b want 0", i, in_ready);
            end
         end
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      tests++;
      if ({lat[3:0], out, co, nf} !== {4'd3, 8'h84, 2'b11}) begin
         failed++;
         $display("FAIL ashl got lat=%0d out=%h co=%b nf=%b want lat=3 out=84 co=1 nf=1",
                  lat, out, co, nf);
      end
   endtask

   task automatic test_ashr;
      logic r;
      int l0, l1;
      logic [8:0] v0, v1;
      l0 = 0; l1 = 0; v0 = '0; v1 = '0;
      issue(3'b011, 8'h98, 8'h04, r);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (out_valid && l0 == 0) begin l0 = i; v0 = {out, co}; end
         if (out_valid1 && l1 == 0) begin l1 = i; v1 = {out1, co1}; end
      end
      tests++;
      if ({l0[3:0], v0} !== {4'd5, 8'hF9, 1'b1}) begin
         failed++;
         $display("FAIL ashr_iter got lat=%0d out/co=%h want lat=5 F9/1", l0, v0);
      end
      tests++;
      if ({l1[3:0], v1} !== {4'd1, 8'hF9, 1'b1}) begin
         failed++;
         $display("FAIL ashr_barrel got lat=%0d out/co=%h want lat=1 F9/1", l1, v1);
      end
   endtask

   task automatic test_hold;
      logic r;
      int lat;
      @(negedge clk);
      out_ready = 1'b0;
      issue(3'b010, 8'h0F, 8'h0F, r);
      wait_valid(lat);
      tests++;
      if ({lat[3:0], out, zf, nf, in_ready} !== {4'd1, 8'hFF, 3'b010}) begin
         failed++;
         $display("FAIL xnor got lat=%0d out=%h zf=%b nf=%b rdy=%b want FF 0 1 0",
                  lat, out, zf, nf, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if ({out_valid, out, co, zf, nf, in_ready} !== {1'b1, 8'hFF, 4'b0010}) begin
            failed++;
            $display("FAIL hold cycle %0d v=%b out=%h co=%b zf=%b nf=%b rdy=%b",
                     i, out_valid, out, co, zf, nf, in_ready);
         end
      end
      out_ready = 1'b1;
      sel = 3'b101; op1 = 8'h5A; op2 = 8'h00; in_valid = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL release_ready got %b want 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({out_valid, out} !== {1'b1, 8'h5A}) begin
         failed++;
         $display("FAIL passa got v=%b out=%h want 1 5A", out_valid, out);
      end
   endtask

   task automatic test_neg;
      logic r;
      int lat;
      issue(3'b110, 8'h80, 8'h00, r);
      wait_valid(lat);
      tests++;
      if ({out, co, zf, nf} !== {8'h80, 3'b001}) begin
         failed++;
         $display("FAIL neg80 got out=%h co=%b zf=%b nf=%b want 80 0 0 1",
                  out, co, zf, nf);
      end
      issue(3'b110, 8'h00, 8'h00, r);
      wait_valid(lat);
      tests++;
      if ({out, co, zf, nf} !== {8'h00, 3'b010}) begin
         failed++;
         $display("FAIL neg00 got out=%h co=%b zf=%b nf=%b want 00 0 1 0",
                  out, co, zf, nf);
      end
   endtask

   task automatic test_shift_zero;
      logic r;
      int lat;
      issue(3'b001, 8'h85, 8'h00, r);
      wait_valid(lat);
      tests++;
      if ({lat[3:0], out, co, nf} !== {4'd1, 8'h85, 2'b01}) begin
         failed++;
         $display("FAIL ashl0 got lat=%0d out=%h co=%b want lat=1 85 0", lat, out, co);
      end
      issue(3'b011, 8'h85, 8'h08, r);
      wait_valid(lat);
      tests++;
      if ({lat[3:0], out, co} !== {4'd1, 8'h85, 1'b0}) begin
         failed++;
         $display("FAIL ashr0 got lat=%0d out=%h co=%b want lat=1 85 0", lat, out, co);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tests++;
            if ({out_valid, out} !== {1'b1, vals[i-1]}) begin
               failed++;
               $display("FAIL b2b_out %0d got v=%b out=%h want %h",
                        i, out_valid, out, vals[i-1]);
            end
         end
         sel = 3'b100; op1 = 8'h00; op2 = vals[i]; in_valid = 1'b1;
         #1;
         tests++;
         if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL b2b_ready %0d got %b want 1", i, in_ready);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if ({out_valid, out} !== {1'b1, 8'h44}) begin
         failed++;
         $display("FAIL b2b_last got v=%b out=%h want 44", out_valid, out);
      end
   endtask

   task automatic test_reset_mid;
      logic r;
      int lat;
      issue(3'b000, 8'hF0, 8'h20, r);
      wait_valid(lat);
      issue(3'b001, 8'hFF, 8'h03, r);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         failed++;
         $display("FAIL rst_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if ({in_ready, out_valid, out, co, zf, nf} !== {1'b1, 12'd0}) begin
         failed++;
         $display("FAIL rst_mid got rdy=%b v=%b out=%h co=%b zf=%b nf=%b",
                  in_ready, out_valid, out, co, zf, nf);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if ({out_valid, out, co} !== 10'd0) begin
            failed++;
            $display("FAIL rst_quiet %0d got v=%b out=%h co=%b",
                     i, out_valid, out, co);
         end
      end
      issue(3'b111, 8'h01, 8'h01, r);
      wait_valid(lat);
      tests++;
      if ({out, co} !== {8'h02, 1'b0}) begin
         failed++;
         $display("FAIL adc_after_rst got out=%h co=%b want 02 0", out, co);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_ashl;
      test_ashr;
      test_hold;
      test_neg;
      test_shift_zero;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
